accelerator_hls_deadlock_reporter: RTL and testbench

- Consumes the 1-bit `block` output of the top-level dataflow deadlock monitor for the accelerator instance.
- Filters transient blocks: a deadlock is declared only after `block` has been high for a set number of consecutive cycles.
- On confirmation: raises a sticky flag and a one-cycle pulse, and freezes a snapshot of the raw idle/block/axis vectors for debug readout.
- Sits between the monitor and the debug/status register file.

---
 rtl/accelerator_hls_deadlock_reporter.sv | 125 ++++++++++++
 tb/tb_accelerator_hls_deadlock_reporter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_hls_deadlock_reporter.sv
// Debounces the dataflow monitor's block indication into a sticky deadlock flag and freezes a debug snapshot.
// Optional macro ACCEL_DEADLOCK_STALL_CNT_EN enables the CONFIRMED-state stall cycle counter.
module accelerator_hls_deadlock_reporter #(
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int IDLE_W         = 9,
  parameter int BLOCK_W        = 4,
  parameter int AXIS_W         = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               block_in,
  input  logic [IDLE_W-1:0]  inst_idle_sigs,
  input  logic [BLOCK_W-1:0] inst_block_sigs,
  input  logic [AXIS_W-1:0]  axis_block_sigs,
  input  logic               clear,
  output logic               deadlock,
  output logic               deadlock_pulse,
  output logic [IDLE_W-1:0]  snap_idle,
  output logic [BLOCK_W-1:0] snap_block,
  output logic [AXIS_W-1:0]  snap_axis,
  output logic [CNT_W-1:0]   event_count,
  output logic [CNT_W-1:0]   stall_cycles
);

  // run_cnt only ever holds 1..CONFIRM_CYCLES-1, so log2 bits suffice.
  localparam int                RUN_W    = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam logic [RUN_W-1:0]  LAST_RUN = RUN_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CONFIRMED,
    ST_REARM
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic             confirm;

  // NOTE: combinational logic assigns a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    confirm = 1'b0;
    if (block_in) begin
      if (state == ST_IDLE && CONFIRM_CYCLES == 1)
        confirm = 1'b1;
      else if (state == ST_ARMED && run_cnt == LAST_RUN)
        confirm = 1'b1;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      run_cnt        <= '0;
      deadlock       <= 1'b0;
      deadlock_pulse <= 1'b0;
      snap_idle      <= '0;
      snap_block     <= '0;
      snap_axis      <= '0;
      event_count    <= '0;
    end else begin
      deadlock_pulse <= 1'b0;
      if (confirm) begin
        state          <= ST_CONFIRMED;
        run_cnt        <= '0;
        deadlock       <= 1'b1;
        deadlock_pulse <= 1'b1;
        snap_idle      <= inst_idle_sigs;
        snap_block     <= inst_block_sigs;
        snap_axis      <= axis_block_sigs;
        if (event_count != CNT_MAX)
          event_count <= event_count + 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (block_in) begin
              state   <= ST_ARMED;
              run_cnt <= RUN_W'(1);
            end
          end
          ST_ARMED: begin
            // A single low sample throws away the whole run.
            if (!block_in) begin
              state   <= ST_IDLE;
              run_cnt <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
          ST_CONFIRMED: begin
            if (clear) begin
              deadlock <= 1'b0;
              state    <= ST_REARM;
            end
          end
          ST_REARM: begin
            // A block that never drops cannot re-trigger.
            if (!block_in)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ACCEL_DEADLOCK_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_cycles <= '0;
    else if (confirm)
      stall_cycles <= '0;
    else if (state == ST_CONFIRMED && stall_cycles != CNT_MAX)
      stall_cycles <= stall_cycles + 1'b1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_accelerator_hls_deadlock_reporter.sv
// Scoreboard bench: stimulus pushes expected snapshots, monitors pop them on each deadlock_pulse.
module tb_accelerator_hls_deadlock_reporter;

  typedef struct {
    logic [8:0] idle;
    logic [3:0] blk;
    logic [1:0] axis;
    logic [7:0] evt;
  } exp_t;

  logic       clock, reset;
  logic       b16, c16, b1, c1;
  logic [8:0] idle;
  logic [3:0] blk;
  logic [1:0] axis;

  logic       dl16, p16, dl1, p1;
  logic [8:0] si16, si1;
  logic [3:0] sb16, sb1;
  logic [1:0] sa16, sa1;
  logic [7:0] ev16, ev1, st16, st1;

  exp_t q16[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  logic prev16 = 1'b0;
  logic prev1  = 1'b0;

  accelerator_hls_deadlock_reporter #(.CONFIRM_CYCLES(16)) u16 (
    .clock(clock), .reset(reset), .block_in(b16),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .axis_block_sigs(axis),
    .clear(c16), .deadlock(dl16), .deadlock_pulse(p16),
    .snap_idle(si16), .snap_block(sb16), .snap_axis(sa16),
    .event_count(ev16), .stall_cycles(st16)
  );

  accelerator_hls_deadlock_reporter #(.CONFIRM_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .block_in(b1),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .axis_block_sigs(axis),
    .clear(c1), .deadlock(dl1), .deadlock_pulse(p1),
    .snap_idle(si1), .snap_block(sb1), .snap_axis(sa1),
    .event_count(ev1), .stall_cycles(st1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stall(input int v);
`ifdef ACCEL_DEADLOCK_STALL_CNT_EN
    return (v > 255) ? 32'd255 : 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitors: every pulse must match the oldest expected confirmation.
  always @(negedge clock) begin
    if (p16) begin
      check("p16_width", 32'(prev16), 32'd0);
      if (q16.size() == 0) begin
        check("p16_unexpected", 32'(p16), 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("p16_deadlock", 32'(dl16), 32'd1);
        check("p16_snap_idle", 32'(si16), 32'(e.idle));
        check("p16_snap_block", 32'(sb16), 32'(e.blk));
        check("p16_snap_axis", 32'(sa16), 32'(e.axis));
        check("p16_event_count", 32'(ev16), 32'(e.evt));
      end
    end
    prev16 = p16;
  end

  always @(negedge clock) begin
    if (p1) begin
      check("p1_width", 32'(prev1), 32'd0);
      if (q1.size() == 0) begin
        check("p1_unexpected", 32'(p1), 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("p1_deadlock", 32'(dl1), 32'd1);
        check("p1_snap_idle", 32'(si1), 32'(e.idle));
        check("p1_snap_block", 32'(sb1), 32'(e.blk));
        check("p1_snap_axis", 32'(sa1), 32'(e.axis));
        check("p1_event_count", 32'(ev1), 32'(e.evt));
      end
    end
    prev1 = p1;
  end

  task automatic check_zero16(input string tag);
    check({tag, "_deadlock"}, 32'(dl16), 32'd0);
    check({tag, "_pulse"}, 32'(p16), 32'd0);
    check({tag, "_snap_idle"}, 32'(si16), 32'd0);
    check({tag, "_snap_block"}, 32'(sb16), 32'd0);
    check({tag, "_snap_axis"}, 32'(sa16), 32'd0);
    check({tag, "_event_count"}, 32'(ev16), 32'd0);
    check({tag, "_stall"}, 32'(st16), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    b16 = 1'b0; c16 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    idle = '0; blk = '0; axis = '0;
    tick();
    tick();
    check_zero16("reset");
    reset = 1'b0;

    // 15 high cycles then low: no confirmation.
    b16 = 1'b1;
    repeat (15) tick();
    check("short_run_deadlock", 32'(dl16), 32'd0);
    b16 = 1'b0;
    tick();
    check("short_run_deadlock_after", 32'(dl16), 32'd0);
    check("short_run_event_count", 32'(ev16), 32'd0);

    // 16 high cycles with the debug vectors on the 16th.
    b16 = 1'b1;
    repeat (15) tick();
    check("run15_deadlock", 32'(dl16), 32'd0);
    idle = 9'h1A5; blk = 4'h6; axis = 2'b10;
    q16.push_back('{idle: 9'h1A5, blk: 4'h6, axis: 2'b10, evt: 8'd1});
    tick();
    idle = '0; blk = '0; axis = '0;
    check("confirm1_deadlock", 32'(dl16), 32'd1);
    check("confirm1_pulse", 32'(p16), 32'd1);
    check("confirm1_stall", 32'(st16), 32'd0);
    tick();
    check("confirm1_pulse_drop", 32'(p16), 32'd0);
    check("confirm1_sticky", 32'(dl16), 32'd1);
    repeat (9) tick();
    check("stall_10", 32'(st16), exp_stall(10));
    repeat (290) tick();
    check("stall_300", 32'(st16), exp_stall(300));
    check("confirmed_sticky_300", 32'(dl16), 32'd1);

    // Clear while block stays high: drops flag, no re-trigger.
    c16 = 1'b1;
    tick();
    c16 = 1'b0;
    check("clear_deadlock", 32'(dl16), 32'd0);
    repeat (40) tick();
    check("rearm_hold_deadlock", 32'(dl16), 32'd0);
    check("rearm_hold_event_count", 32'(ev16), 32'd1);
    check("rearm_hold_stall", 32'(st16), exp_stall(300));
    check("rearm_hold_snap_idle", 32'(si16), 32'h1A5);

    // One low cycle, then a second confirmation; clears in ARMED and on
    // the confirming cycle must be ignored.
    b16 = 1'b0;
    tick();
    b16 = 1'b1;
    repeat (4) tick();
    c16 = 1'b1;
    tick();
    c16 = 1'b0;
    repeat (10) tick();
    check("run2_15_deadlock", 32'(dl16), 32'd0);
    idle = 9'h05A; blk = 4'h9; axis = 2'b01; c16 = 1'b1;
    q16.push_back('{idle: 9'h05A, blk: 4'h9, axis: 2'b01, evt: 8'd2});
    tick();
    c16 = 1'b0; idle = '0; blk = '0; axis = '0;
    check("confirm2_deadlock", 32'(dl16), 32'd1);
    check("confirm2_event_count", 32'(ev16), 32'd2);
    check("confirm2_stall_zeroed", 32'(st16), 32'd0);
    tick();
    check("confirm2_clear_same_edge_ignored", 32'(dl16), 32'd1);
    b16 = 1'b0; c16 = 1'b1;
    tick();
    c16 = 1'b0;
    check("clear2_deadlock", 32'(dl16), 32'd0);
    tick();
    check("idle_stall_hold", 32'(st16), exp_stall(2));
    check("snap_kept_after_clear", 32'(si16), 32'h05A);

    // Reset in ARMED at run_cnt=10 discards the run.
    b16 = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero16("midreset");
    repeat (15) tick();
    check("post_reset_15_deadlock", 32'(dl16), 32'd0);
    idle = 9'h100; blk = 4'h1; axis = 2'b11;
    q16.push_back('{idle: 9'h100, blk: 4'h1, axis: 2'b11, evt: 8'd1});
    tick();
    idle = '0; blk = '0; axis = '0; b16 = 1'b0;
    check("post_reset_confirm", 32'(dl16), 32'd1);
    check("post_reset_event_count", 32'(ev16), 32'd1);
    tick();

    // CONFIRM_CYCLES=1: a single high sample confirms.
    check("c1_initial_deadlock", 32'(dl1), 32'd0);
    b1 = 1'b1; idle = 9'h0FF; blk = 4'hF; axis = 2'b11;
    q1.push_back('{idle: 9'h0FF, blk: 4'hF, axis: 2'b11, evt: 8'd1});
    tick();
    b1 = 1'b0; idle = '0; blk = '0; axis = '0;
    check("c1_confirm", 32'(dl1), 32'd1);
    check("c1_event_count", 32'(ev1), 32'd1);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    check("c1_clear", 32'(dl1), 32'd0);
    tick();
    b1 = 1'b1; idle = 9'h02A; blk = 4'h5; axis = 2'b00;
    q1.push_back('{idle: 9'h02A, blk: 4'h5, axis: 2'b00, evt: 8'd2});
    tick();
    b1 = 1'b0; idle = '0; blk = '0; axis = '0;
    check("c1_confirm2", 32'(dl1), 32'd1);
    check("c1_event_count2", 32'(ev1), 32'd2);

    tick();
    tick();
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
